// File: rtl/mod_inv_bin_hs.sv
// Modular inverter a^-1 mod p using binary extended Euclid, one reduction
// step per clock. The modulus is a run-time input, so several curves can
// share one instance. Requests use a start/busy handshake and results use
// a valid/ready handshake. Bad inputs, gcd != 1 and step overrun are all
// reported through err.
module mod_inv_bin_hs #(
    parameter int WIDTH    = 255,
    parameter int MAX_ITER = 4*WIDTH+4,
    parameter int CW       = $clog2(MAX_ITER+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] inv,
    output logic             err,
    output logic [CW-1:0]    iters
);

    // One spare bit so that x + p never overflows the working registers.
    localparam int XW = WIDTH + 1;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]    ZERO_X = {XW{1'b0}};
    localparam logic [XW-1:0]    ONE_X  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    MAX_C  = CW'(MAX_ITER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [XW-1:0]    u_r, u_s;
    logic [XW-1:0]    v_r, v_s;
    logic [XW-1:0]    x1_r, x1_s;
    logic [XW-1:0]    x2_r, x2_s;
    logic [XW-1:0]    p_r, p_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [CW-1:0]    iters_r, iters_s;
    logic [WIDTH-1:0] inv_r, inv_s;
    logic             err_r, err_s;
    logic             busy_r, busy_s;
    logic             valid_r, valid_s;
    logic             bad_in_s;

    // x/2 mod m for odd m: add m first when x is odd so the halving is exact.
    function automatic logic [XW-1:0] half_mod(input logic [XW-1:0] x,
                                               input logic [XW-1:0] m);
        logic [XW-1:0] t;
        if (x[0] == 1'b0) begin
            t = x;
        end else begin
            t = x + m;
        end
        return {1'b0, t[XW-1:1]};
    endfunction

    // (x - y) mod m for x, y already in [0, m).
    function automatic logic [XW-1:0] sub_mod(input logic [XW-1:0] x,
                                              input logic [XW-1:0] y,
                                              input logic [XW-1:0] m);
        logic [XW-1:0] t;
        if (x >= y) begin
            t = x - y;
        end else begin
            t = x + m - y;
        end
        return t;
    endfunction

    // Input screening: even or trivial modulus, or operand outside [1, p-1].
    always_comb begin
        bad_in_s = (p[0] == 1'b0) || (p <= ONE_W) || (a == ZERO_W) || (a >= p);
    end

    // Next-state and datapath update for the IDLE / RUN / OUT sequence.
    always_comb begin
        state_s = state_r;
        u_s     = u_r;
        v_s     = v_r;
        x1_s    = x1_r;
        x2_s    = x2_r;
        p_s     = p_r;
        cnt_s   = cnt_r;
        iters_s = iters_r;
        inv_s   = inv_r;
        err_s   = err_r;
        busy_s  = busy_r;
        valid_s = valid_r;
        case (state_r)
            ST_IDLE: begin
                if (start == 1'b1) begin
                    busy_s = 1'b1;
                    if (bad_in_s == 1'b1) begin
                        state_s = ST_OUT;
                        valid_s = 1'b1;
                        err_s   = 1'b1;
                        inv_s   = ZERO_W;
                        iters_s = ZERO_C;
                    end else begin
                        state_s = ST_RUN;
                        u_s     = {1'b0, a};
                        v_s     = {1'b0, p};
                        p_s     = {1'b0, p};
                        x1_s    = ONE_X;
                        x2_s    = ZERO_X;
                        cnt_s   = ZERO_C;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (u_r == ONE_X) begin
                    state_s = ST_OUT;
                    valid_s = 1'b1;
                    inv_s   = x1_r[WIDTH-1:0];
                    err_s   = 1'b0;
                    iters_s = cnt_r;
                end else if (v_r == ONE_X) begin
                    state_s = ST_OUT;
                    valid_s = 1'b1;
                    inv_s   = x2_r[WIDTH-1:0];
                    err_s   = 1'b0;
                    iters_s = cnt_r;
                end else if ((u_r == ZERO_X) || (v_r == ZERO_X)) begin
                    // One side reached zero before one: gcd(a, p) != 1.
                    state_s = ST_OUT;
                    valid_s = 1'b1;
                    inv_s   = ZERO_W;
                    err_s   = 1'b1;
                    iters_s = cnt_r;
                end else if (cnt_r == MAX_C) begin
                    state_s = ST_OUT;
                    valid_s = 1'b1;
                    inv_s   = ZERO_W;
                    err_s   = 1'b1;
                    iters_s = cnt_r;
                end else begin
                    // Invariants: x1*a == u and x2*a == v (mod p).
                    cnt_s = cnt_r + ONE_C;
                    if (u_r[0] == 1'b0) begin
                        u_s  = {1'b0, u_r[XW-1:1]};
                        x1_s = half_mod(x1_r, p_r);
                    end else if (v_r[0] == 1'b0) begin
                        v_s  = {1'b0, v_r[XW-1:1]};
                        x2_s = half_mod(x2_r, p_r);
                    end else if (u_r >= v_r) begin
                        u_s  = u_r - v_r;
                        x1_s = sub_mod(x1_r, x2_r, p_r);
                    end else begin
                        v_s  = v_r - u_r;
                        x2_s = sub_mod(x2_r, x1_r, p_r);
                    end
                end
            end
            ST_OUT: begin
                // A start during the consuming cycle is ignored because
                // the FSM only looks at start while in IDLE.
                if (out_ready == 1'b1) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run without a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            u_r     <= ZERO_X;
            v_r     <= ZERO_X;
            x1_r    <= ZERO_X;
            x2_r    <= ZERO_X;
            p_r     <= ZERO_X;
            cnt_r   <= ZERO_C;
            iters_r <= ZERO_C;
            inv_r   <= ZERO_W;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            u_r     <= u_s;
            v_r     <= v_s;
            x1_r    <= x1_s;
            x2_r    <= x2_s;
            p_r     <= p_s;
            cnt_r   <= cnt_s;
            iters_r <= iters_s;
            inv_r   <= inv_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            valid_r <= valid_s;
        end
    end

    assign busy      = busy_r;
    assign out_valid = valid_r;
    assign inv       = inv_r;
    assign err       = err_r;
    assign iters     = iters_r;

endmodule

// File: tb/tb_mod_inv_bin_hs.sv
// Self-checking bench: an 8-bit instance for directed/handshake/error cases
// and a default 255-bit instance checked against a Fermat-inverse model.
module tb_mod_inv_bin_hs;

    localparam int W8   = 8;
    localparam int MI8  = 4*W8+4;
    localparam int CW8  = $clog2(MI8+1);
    localparam int WB   = 255;
    localparam int MIB  = 4*WB+4;
    localparam int CWB  = $clog2(MIB+1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            start8, busy8, ov8, ordy8, err8;
    logic [W8-1:0]   a8, p8, inv8;
    logic [CW8-1:0]  iters8;

    logic            startb, busyb, ovb, ordyb, errb;
    logic [WB-1:0]   ab, pb, invb;
    logic [CWB-1:0]  itersb;

    int vectors = 0;
    int miscompares = 0;

    mod_inv_bin_hs #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .p(p8),
        .busy(busy8), .out_valid(ov8), .out_ready(ordy8),
        .inv(inv8), .err(err8), .iters(iters8)
    );

    mod_inv_bin_hs dutb (
        .clk(clk), .rst_n(rst_n), .start(startb), .a(ab), .p(pb),
        .busy(busyb), .out_valid(ovb), .out_ready(ordyb),
        .inv(invb), .err(errb), .iters(itersb)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit rule_err8(input logic [7:0] a, input logic [7:0] p);
        return (p[0] == 1'b0) || (p <= 8'd1) || (a == 8'd0) || (a >= p);
    endfunction

    // Reference: {err, inv} by exhaustive search for i with a*i == 1 mod p.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] p);
        if (rule_err8(a, p)) return {1'b1, 8'd0};
        for (int i = 1; i < int'(p); i++) begin
            if ((int'(a) * i) % int'(p) == 1) return {1'b0, 8'(i)};
        end
        return {1'b1, 8'd0};
    endfunction

    // Reference for prime m: a^(m-2) mod m.
    function automatic logic [254:0] ref_inv(input logic [254:0] a, input logic [254:0] m);
        logic [511:0] r, x, mm;
        logic [254:0] e;
        mm = 512'(m);
        e  = m - 255'd2;
        r  = 512'd1;
        x  = 512'(a) % mm;
        for (int i = 0; i < 255; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[254:0];
    endfunction

    // One 8-bit transaction with out_ready held high.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] p,
                       output int lat, output logic [CW8-1:0] it);
        logic [8:0] e;
        bit re;
        e  = ref8(a, p);
        re = rule_err8(a, p);
        @(negedge clk); start8 = 1'b1; a8 = a; p8 = p;
        @(negedge clk); start8 = 1'b0; a8 = 8'($urandom); p8 = 8'($urandom);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        it = iters8;
        chk({tag, " valid"}, 256'(ov8), 256'(1));
        chk({tag, " inv"}, 256'(inv8), 256'(e[7:0]));
        chk({tag, " err"}, 256'(err8), 256'(e[8]));
        chk({tag, " iters_bound"}, 256'(iters8 <= CW8'(MI8)), 256'(1));
        if (re) begin
            chk({tag, " latency"}, 256'(lat), 256'(0));
            chk({tag, " iters"}, 256'(iters8), 256'(0));
        end else begin
            chk({tag, " latency"}, 256'(lat), 256'(int'(iters8) + 1));
        end
        @(negedge clk);
        chk({tag, " valid_one_cycle"}, 256'(ov8), 256'(0));
    endtask

    // One 255-bit transaction; checks inverse against the Fermat model.
    task automatic opb(input string tag, input logic [254:0] a);
        logic [254:0] e;
        logic [511:0] prod;
        int lat;
        e = ref_inv(a, pb);
        @(negedge clk); startb = 1'b1; ab = a;
        @(negedge clk); startb = 1'b0; ab = {8{$urandom}};
        lat = 0;
        while (ovb !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
        chk({tag, " valid"}, 256'(ovb), 256'(1));
        chk({tag, " inv"}, 256'(invb), 256'(e));
        chk({tag, " err"}, 256'(errb), 256'(0));
        chk({tag, " iters_bound"}, 256'(itersb <= CWB'(MIB)), 256'(1));
        chk({tag, " latency"}, 256'(lat), 256'(int'(itersb) + 1));
        prod = (512'(a) * 512'(invb)) % 512'(pb);
        chk({tag, " a_times_inv"}, prod[255:0], 256'(1));
        @(negedge clk);
        chk({tag, " valid_one_cycle"}, 256'(ovb), 256'(0));
    endtask

    initial begin
        int lat, n;
        logic [CW8-1:0] it, hold_it;
        logic [W8-1:0] hold_inv;
        logic [255:0] rnd;
        logic [254:0] ra, e2;
        logic [7:0] plist [8];
        bit seen;

        plist = '{8'd251, 8'd15, 8'd97, 8'd255, 8'd9, 8'd3, 8'd1, 8'd250};
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'd0; p8 = 8'd0; ordy8 = 1'b1;
        startb = 1'b0; ab = '0; pb = '1; ordyb = 1'b1;
        pb = pb - 255'd18;                      // 2^255 - 19
        repeat (3) @(negedge clk);
        chk("rst busy", 256'(busy8), 256'(0));
        chk("rst valid", 256'(ov8), 256'(0));
        chk("rst inv", 256'(inv8), 256'(0));
        chk("rst err", 256'(err8), 256'(0));
        chk("rst iters", 256'(iters8), 256'(0));
        chk("rst valid255", 256'(ovb), 256'(0));
        chk("rst busy255", 256'(busyb), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed inverses
        op8("inv3", 8'd3, 8'd251, lat, it);
        chk("inv3 const", 256'(inv8), 256'(84));
        op8("inv2", 8'd2, 8'd251, lat, it);
        chk("inv2 const", 256'(inv8), 256'(126));
        op8("inv1", 8'd1, 8'd251, lat, it);
        chk("inv1 const", 256'(inv8), 256'(1));
        chk("inv1 latency", 256'(lat), 256'(1));
        chk("inv1 iters", 256'(it), 256'(0));
        op8("inv250", 8'd250, 8'd251, lat, it);
        chk("inv250 const", 256'(inv8), 256'(250));

        // Error paths
        op8("err_a0", 8'd0, 8'd251, lat, it);
        chk("err_a0 err", 256'(err8), 256'(1));
        op8("err_peven", 8'd3, 8'd250, lat, it);
        chk("err_peven err", 256'(err8), 256'(1));
        op8("err_gcd", 8'd5, 8'd15, lat, it);
        chk("err_gcd err", 256'(err8), 256'(1));
        chk("err_gcd from_run", 256'(lat >= 1), 256'(1));
        op8("err_aeqp", 8'd251, 8'd251, lat, it);
        chk("err_aeqp err", 256'(err8), 256'(1));

        // Random 8-bit operands over several moduli
        for (int k = 0; k < 40; k++) begin
            op8("rand8", 8'($urandom_range(0, 255)), plist[$urandom_range(0, 7)], lat, it);
        end

        // Backpressure: result held, start ignored, one handshake
        ordy8 = 1'b0;
        @(negedge clk); start8 = 1'b1; a8 = 8'd7; p8 = 8'd251;
        @(negedge clk); start8 = 1'b0;
        n = 0;
        while (ov8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("bp valid", 256'(ov8), 256'(1));
        chk("bp inv", 256'(inv8), 256'(ref8(8'd7, 8'd251)));
        hold_inv = inv8; hold_it = iters8;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin start8 = 1'b1; a8 = 8'd2; end
            else begin start8 = 1'b0; end
            @(negedge clk);
            chk("bp hold valid", 256'(ov8), 256'(1));
            chk("bp hold inv", 256'(inv8), 256'(hold_inv));
            chk("bp hold iters", 256'(iters8), 256'(hold_it));
            chk("bp hold err", 256'(err8), 256'(0));
        end
        ordy8 = 1'b1; start8 = 1'b1; a8 = 8'd2; p8 = 8'd251;
        @(negedge clk);
        chk("bp handshake valid", 256'(ov8), 256'(0));
        chk("bp start_ignored", 256'(busy8), 256'(0));
        @(negedge clk); start8 = 1'b0;
        chk("bp next_accept", 256'(busy8), 256'(1));
        n = 0;
        while (ov8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("bp new inv", 256'(inv8), 256'(126));
        @(negedge clk);

        // Reset mid-run
        @(negedge clk); start8 = 1'b1; a8 = 8'd3; p8 = 8'd251;
        @(negedge clk); start8 = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid running", 256'(ov8), 256'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst busy", 256'(busy8), 256'(0));
        chk("mid rst valid", 256'(ov8), 256'(0));
        chk("mid rst inv", 256'(inv8), 256'(0));
        chk("mid rst err", 256'(err8), 256'(0));
        chk("mid rst iters", 256'(iters8), 256'(0));
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
        end
        chk("mid no_result", 256'(seen), 256'(0));
        op8("after_rst", 8'd3, 8'd251, lat, it);
        chk("after_rst const", 256'(inv8), 256'(84));

        // 255-bit modulus 2^255-19
        e2 = (255'd1 << 254) - 255'd9;
        opb("b_inv2", 255'd2);
        chk("b_inv2 const", 256'(invb), 256'(e2));
        for (int k = 0; k < 40; k++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            ra = rnd[254:0];
            if (ra >= pb) ra = ra - pb;
            if (ra == 255'd0) ra = 255'd1;
            opb("b_rand", ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
